// File: rtl/coupler_2_to_4.sv
// Packs pairs of 64-bit merger tuples into 128-bit tuples.
// Handles terminators, odd-run padding and a ready-throttled skid FIFO.
module coupler_2_to_4 #(
  parameter int REC_W        = 32,
  parameter int IN_RECS      = 2,
  parameter int BUF_DEPTH    = 4,
  parameter int READY_THRESH = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_write,
  input  logic [IN_RECS*REC_W-1:0]     i_data,
  output logic                         o_ready,
  input  logic                         i_out_ready,
  output logic                         o_write,
  output logic [2*IN_RECS*REC_W-1:0]   o_data,
  output logic                         o_overrun,
  output logic [15:0]                  o_pair_count
);

  localparam int IN_W  = IN_RECS * REC_W;
  localparam int OUT_W = 2 * IN_W;
  localparam int AW    = $clog2(BUF_DEPTH);

  localparam logic [AW:0] FULL_C = (AW + 1)'(BUF_DEPTH);
  localparam logic [AW:0] THR_C  = (AW + 1)'(READY_THRESH);

  typedef enum logic [1:0] {
    EMPTY,
    HAVE_LOW,
    FLUSH_TERM
  } state_t;

  logic [IN_W-1:0]  mem [BUF_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [IN_W-1:0]  head;
  logic             head_zero;
  logic [IN_W-1:0]  low;
  logic             load_low;
  logic             emit;
  logic [OUT_W-1:0] emit_data;
  state_t           state;
  state_t           state_n;

  assign full      = (count == FULL_C);
  assign empty     = (count == '0);
  assign push      = i_write && !full;
  assign head      = mem[rd_ptr];
  assign head_zero = (head == '0);
  assign o_ready   = (count <= THR_C);

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Nothing moves unless downstream can take a tuple.
  always_comb begin
    state_n   = state;
    pop       = 1'b0;
    load_low  = 1'b0;
    emit      = 1'b0;
    emit_data = '0;
    unique case (state)
      EMPTY: begin
        if (!empty && i_out_ready) begin
          pop = 1'b1;
          if (head_zero) begin
            emit = 1'b1;
          end else begin
            load_low = 1'b1;
            state_n  = HAVE_LOW;
          end
        end
      end
      HAVE_LOW: begin
        if (!empty && i_out_ready) begin
          emit = 1'b1;
          if (head_zero) begin
            emit_data = {{IN_W{1'b0}}, low};
            state_n   = FLUSH_TERM;
          end else begin
            pop       = 1'b1;
            emit_data = {head, low};
            state_n   = EMPTY;
          end
        end
      end
      FLUSH_TERM: begin
        if (!empty && i_out_ready) begin
          pop     = 1'b1;
          emit    = 1'b1;
          state_n = EMPTY;
        end
      end
      default: begin
        state_n = EMPTY;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= EMPTY;
      low          <= '0;
      o_write      <= 1'b0;
      o_data       <= '0;
      o_overrun    <= 1'b0;
      o_pair_count <= '0;
    end else begin
      state   <= state_n;
      o_write <= emit;
      if (load_low) begin
        low <= head;
      end
      if (emit) begin
        o_data       <= emit_data;
        o_pair_count <= o_pair_count + 16'd1;
      end
      if (i_write && full) begin
        o_overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_coupler_2_to_4.sv
// Bench for coupler_2_to_4: directed scenarios plus randomized traffic
// checked against a stream-level pairing model.
module tb_coupler_2_to_4;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr;
  logic [63:0]  din;
  logic         rdy;
  logic         out_rdy;
  logic         owr;
  logic [127:0] dout;
  logic         ovr;
  logic [15:0]  pcnt;

  int total = 0;
  int bad   = 0;

  logic [63:0]  acc[$];
  logic [127:0] exp_q[$];
  logic [127:0] got[$];

  coupler_2_to_4 dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_write      (wr),
    .i_data       (din),
    .o_ready      (rdy),
    .i_out_ready  (out_rdy),
    .o_write      (owr),
    .o_data       (dout),
    .o_overrun    (ovr),
    .o_pair_count (pcnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst !== 1'b1 && owr === 1'b1) got.push_back(dout);
  end

  // Stream rule: pair nonzero tuples, pad an odd run before a terminator.
  function automatic void build_exp();
    logic        have;
    logic [63:0] lo;
    exp_q.delete();
    have = 1'b0;
    lo   = '0;
    foreach (acc[i]) begin
      if (acc[i] == 64'h0) begin
        if (have) exp_q.push_back({64'h0, lo});
        exp_q.push_back(128'h0);
        have = 1'b0;
      end else if (have) begin
        exp_q.push_back({acc[i], lo});
        have = 1'b0;
      end else begin
        lo   = acc[i];
        have = 1'b1;
      end
    end
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    wr  = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    got.delete();
    acc.delete();
  endtask

  task automatic put(input logic [63:0] d);
    wr  = 1'b1;
    din = d;
    acc.push_back(d);
    @(posedge clk); #1;
    wr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    out_rdy = 1'b1;
    rst = 1'b1;
    wr  = 1'b1;
    din = 64'hdead_beef_0000_0001;
    @(posedge clk); #1;
    total++;
    if (owr !== 1'b0 || dout !== 128'h0) begin
      bad++;
      $display("FAIL reset_out: o_write=%b o_data=%h want 0", owr, dout);
    end
    total++;
    if (ovr !== 1'b0 || pcnt !== 16'h0) begin
      bad++;
      $display("FAIL reset_flags: overrun=%b count=%h want 0", ovr, pcnt);
    end
    rst = 1'b0;
    wr  = 1'b0;
    total++;
    if (rdy !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: o_ready=%b want 1", rdy);
    end
    idle(3);
    total++;
    if (got.size() != 0) begin
      bad++;
      $display("FAIL reset_quiet: strobes=%0d want 0", got.size());
    end
    got.delete();
  endtask

  task automatic test_pair();
    do_reset();
    out_rdy = 1'b1;
    put(64'h00000002_00000001);
    put(64'h00000004_00000003);
    idle(5);
    total++;
    if (got.size() != 1) begin
      bad++;
      $display("FAIL pair_n: strobes=%0d want 1", got.size());
    end else if (got[0] !== 128'h00000004_00000003_00000002_00000001) begin
      total++;
      bad++;
      $display("FAIL pair_data: got %h want 00000004000000030000000200000001", got[0]);
    end
    total++;
    if (pcnt !== 16'd1) begin
      bad++;
      $display("FAIL pair_count: got %0d want 1", pcnt);
    end
  endtask

  task automatic test_odd();
    logic [63:0] a;
    a = 64'h00000005_00000005;
    do_reset();
    out_rdy = 1'b1;
    put(a);
    put(64'h0);
    idle(6);
    total++;
    if (got.size() != 2) begin
      bad++;
      $display("FAIL odd_n: strobes=%0d want 2", got.size());
    end else begin
      total++;
      if (got[0] !== {64'h0, a} || got[1] !== 128'h0) begin
        bad++;
        $display("FAIL odd_data: got %h,%h want %h,0", got[0], got[1], {64'h0, a});
      end
    end
    total++;
    if (pcnt !== 16'd2) begin
      bad++;
      $display("FAIL odd_count: got %0d want 2", pcnt);
    end
  endtask

  task automatic test_term_only();
    do_reset();
    out_rdy = 1'b1;
    put(64'h0);
    idle(4);
    total++;
    if (got.size() != 1 || got[0] !== 128'h0) begin
      bad++;
      $display("FAIL term_only: strobes=%0d want 1 zero tuple", got.size());
    end
    got.delete();
    put(64'h0000000b_0000000b);
    put(64'h0000000c_0000000c);
    idle(5);
    total++;
    if (got.size() != 1 || got[0] !== 128'h0000000c_0000000c_0000000b_0000000b) begin
      bad++;
      $display("FAIL term_then_pair: strobes=%0d want 1 packed tuple", got.size());
    end
    total++;
    if (pcnt !== 16'd2) begin
      bad++;
      $display("FAIL term_count: got %0d want 2", pcnt);
    end
  endtask

  task automatic test_backpressure();
    logic prev;
    int   occ;
    int   peak;
    int   rbad;
    do_reset();
    out_rdy = 1'b0;
    prev = 1'b1;
    occ  = 0;
    peak = 0;
    rbad = 0;
    for (int k = 0; k < 8; k++) begin
      if (rdy !== (occ <= 2)) rbad++;
      wr  = prev;
      din = 64'h100 + 64'(k);
      if (prev) begin
        acc.push_back(din);
        occ++;
      end
      if (occ > peak) peak = occ;
      prev = rdy;
      @(posedge clk); #1;
    end
    wr = 1'b0;
    total++;
    if (rbad != 0) begin
      bad++;
      $display("FAIL bp_ready: %0d cycles with wrong o_ready", rbad);
    end
    total++;
    if (peak != 4 || ovr !== 1'b0) begin
      bad++;
      $display("FAIL bp_peak: peak=%0d overrun=%b want 4,0", peak, ovr);
    end
    out_rdy = 1'b1;
    idle(10);
    build_exp();
    total++;
    if (got.size() != exp_q.size()) begin
      bad++;
      $display("FAIL bp_drain_n: strobes=%0d want %0d", got.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        total++;
        if (got[i] !== exp_q[i]) begin
          bad++;
          $display("FAIL bp_drain[%0d]: got %h want %h", i, got[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_overrun();
    do_reset();
    out_rdy = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      wr  = 1'b1;
      din = {32'(k), 32'(k * 17)};
      if (k <= 4) acc.push_back(din);
      @(posedge clk); #1;
    end
    wr = 1'b0;
    total++;
    if (ovr !== 1'b1 || rdy !== 1'b0) begin
      bad++;
      $display("FAIL ovr_set: overrun=%b ready=%b want 1,0", ovr, rdy);
    end
    out_rdy = 1'b1;
    idle(10);
    build_exp();
    total++;
    if (got.size() != 2 || got[0] !== exp_q[0] || got[1] !== exp_q[1]) begin
      bad++;
      $display("FAIL ovr_drain: strobes=%0d want 2 tuples of first four inputs", got.size());
    end
    total++;
    if (ovr !== 1'b1) begin
      bad++;
      $display("FAIL ovr_sticky: overrun=%b want 1", ovr);
    end
    do_reset();
    total++;
    if (ovr !== 1'b0) begin
      bad++;
      $display("FAIL ovr_clear: overrun=%b want 0", ovr);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_rdy = 1'b1;
    put(64'h0000aaaa_0000aaaa);
    idle(2);
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (owr !== 1'b0 || dout !== 128'h0) begin
      bad++;
      $display("FAIL mid_reset: o_write=%b o_data=%h want 0", owr, dout);
    end
    rst = 1'b0;
    got.delete();
    put(64'h0000bbbb_0000bbbb);
    put(64'h0000cccc_0000cccc);
    idle(5);
    total++;
    if (got.size() != 1 || got[0] !== 128'h0000cccc_0000cccc_0000bbbb_0000bbbb) begin
      bad++;
      $display("FAIL mid_fresh: strobes=%0d want 1 fresh pair", got.size());
    end
  endtask

  task automatic test_random();
    logic        prev;
    logic        w;
    logic [63:0] d;
    do_reset();
    prev = 1'b1;
    for (int k = 0; k < 600; k++) begin
      out_rdy = ($urandom_range(0, 9) < 7);
      w = prev && ($urandom_range(0, 9) < 8);
      d = ($urandom_range(0, 9) < 2) ? 64'h0 : {$urandom, $urandom};
      wr  = w;
      din = d;
      if (w) acc.push_back(d);
      prev = rdy;
      @(posedge clk); #1;
    end
    wr = 1'b0;
    out_rdy = 1'b1;
    idle(10);
    put(64'h0);
    idle(10);
    build_exp();
    total++;
    if (got.size() != exp_q.size()) begin
      bad++;
      $display("FAIL rand_n: strobes=%0d want %0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      total++;
      if (got[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL rand[%0d]: got %h want %h", i, got[i], exp_q[i]);
      end
    end
    total++;
    if (pcnt !== 16'(exp_q.size()) || ovr !== 1'b0) begin
      bad++;
      $display("FAIL rand_flags: count=%0d overrun=%b want %0d,0", pcnt, ovr, exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    wr = 1'b0;
    din = '0;
    out_rdy = 1'b1;
    test_reset();
    test_pair();
    test_odd();
    test_term_only();
    test_backpressure();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
